// File: rtl/qbert_map_pkg.sv
// Shared definitions for the Qbert pyramid map colour logic: controller FSM
// states, colour-rule encodings and the default cube count.
package qbert_map_pkg;

  localparam int N_CUBE_DEF = 28;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_LATCH  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_WIN    = 3'd5,
    ST_DONE   = 3'd6
  } ctrl_state_e;

  typedef enum logic [1:0] {
    MODE_ONE_HIT = 2'd0,
    MODE_TWO_HIT = 2'd1,
    MODE_TOGGLE  = 2'd2,
    MODE_RSVD    = 2'd3
  } color_mode_e;

endpackage

// File: rtl/cube_flash_timer.sv
// Win flash timer: toggles flash every FLASH_HALF cycles and pulses done on the
// FLASH_TOGGLES-th toggle, leaving flash low. Only built with CUBE_WIN_FLASH_EN.
module cube_flash_timer #(
  parameter int unsigned FLASH_HALF    = 32'd1_650_000,
  parameter int unsigned FLASH_TOGGLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic pause,
  output logic flash,
  output logic done
);

  localparam int              TW        = $clog2(FLASH_TOGGLES + 1);
  localparam logic [31:0]     HALF_LAST = 32'(FLASH_HALF - 1);
  localparam logic [TW-1:0]   TOG_LAST  = TW'(FLASH_TOGGLES - 1);

  logic          active_q, active_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [TW-1:0] tog_q, tog_d;
  logic          flash_q, flash_d;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    tog_d    = tog_q;
    flash_d  = flash_q;
    done     = 1'b0;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      tog_d    = '0;
      flash_d  = 1'b0;
    end else if (active_q && !pause) begin
      if (cnt_q == HALF_LAST) begin
        cnt_d = '0;
        // The last toggle always lands flash at 0 and ends the sequence.
        if (tog_q == TOG_LAST) begin
          active_d = 1'b0;
          tog_d    = '0;
          flash_d  = 1'b0;
          done     = 1'b1;
        end else begin
          tog_d   = tog_q + 1'b1;
          flash_d = ~flash_q;
        end
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      tog_q    <= '0;
      flash_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      tog_q    <= tog_d;
      flash_q  <= flash_d;
    end
  end

  assign flash = flash_q;

endmodule

// File: rtl/cube_color_controller.sv
// Cube colour controller: applies Qbert landings to per-cube colour state and
// detects level completion. Win flash sequence is built under CUBE_WIN_FLASH_EN.
module cube_color_controller
  import qbert_map_pkg::*;
#(
  parameter int          N_CUBE        = N_CUBE_DEF,
  parameter int unsigned FLASH_HALF    = 32'd1_650_000,
  parameter int unsigned FLASH_TOGGLES = 8
) (
  input  logic              CLK_33,
  input  logic              reset,
  input  logic              e_start_qb,
  input  logic              e_pause_qb,
  input  logic              done_move,
  input  logic [N_CUBE-1:0] position_qb,
  input  logic [1:0]        e_mode,
  output logic [N_CUBE-1:0] color_state,
  output logic [N_CUBE-1:0] color_mid,
  output logic [4:0]        cubes_left,
  output logic              level_done,
  output logic              land_err,
  output logic              flash,
  output logic [2:0]        ctrl_state
);

  localparam logic [4:0] LEFT_FULL = 5'(N_CUBE);

  ctrl_state_e       state_q, state_d;
  color_mode_e       mode;
  logic              done_move_q;
  logic              pending_q, pending_d;
  logic [N_CUBE-1:0] pos_q, pos_d;
  logic [N_CUBE-1:0] color_q, color_d;
  logic [N_CUBE-1:0] mid_q, mid_d;
  logic [4:0]        left_q, left_d;
  logic              level_done_q, level_done_d;
  logic              land_err_q, land_err_d;
  logic              edge_det, hit_color, hit_mid;
  logic [4:0]        left_dec, left_inc;
  logic              win_start, win_done;

  assign mode      = color_mode_e'(e_mode);
  assign edge_det  = done_move & ~done_move_q;
  assign hit_color = |(color_q & pos_q);
  assign hit_mid   = |(mid_q & pos_q);
  assign left_dec  = (left_q == 5'd0) ? 5'd0 : left_q - 5'd1;
  assign left_inc  = (left_q >= LEFT_FULL) ? LEFT_FULL : left_q + 5'd1;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    pos_d        = pos_q;
    color_d      = color_q;
    mid_d        = mid_q;
    left_d       = left_q;
    level_done_d = 1'b0;
    land_err_d   = 1'b0;
    win_start    = 1'b0;
    if (e_pause_qb) begin
      // Frozen: only remember that a landing happened.
      if (edge_det) pending_d = 1'b1;
    end else if (e_start_qb) begin
      state_d   = ST_PLAY;
      pending_d = 1'b0;
      color_d   = '0;
      mid_d     = '0;
      left_d    = LEFT_FULL;
    end else begin
      if (edge_det && (state_q == ST_LATCH || state_q == ST_UPDATE ||
                       state_q == ST_CHECK)) begin
        pending_d = 1'b1;
      end
      case (state_q)
        ST_IDLE, ST_DONE: state_d = state_q;
        ST_PLAY: begin
          if (pending_q || edge_det) begin
            state_d   = ST_LATCH;
            pending_d = 1'b0;
          end
        end
        ST_LATCH: begin
          pos_d   = position_qb;
          state_d = ST_UPDATE;
        end
        ST_UPDATE: begin
          state_d = ST_CHECK;
          if (!$onehot(pos_q)) begin
            land_err_d = 1'b1;
          end else begin
            case (mode)
              MODE_TWO_HIT: begin
                if (!hit_color) begin
                  if (hit_mid) begin
                    color_d = color_q | pos_q;
                    mid_d   = mid_q & ~pos_q;
                    left_d  = left_dec;
                  end else begin
                    mid_d = mid_q | pos_q;
                  end
                end
              end
              MODE_TOGGLE: begin
                color_d = color_q ^ pos_q;
                left_d  = hit_color ? left_inc : left_dec;
              end
              default: begin
                if (!hit_color) begin
                  color_d = color_q | pos_q;
                  left_d  = left_dec;
                end
              end
            endcase
          end
        end
        ST_CHECK: begin
          if (left_q == 5'd0) begin
            state_d      = ST_WIN;
            level_done_d = 1'b1;
            win_start    = 1'b1;
          end else begin
            state_d = ST_PLAY;
          end
        end
        ST_WIN:  if (win_done) state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_33) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      done_move_q  <= 1'b0;
      pending_q    <= 1'b0;
      pos_q        <= '0;
      color_q      <= '0;
      mid_q        <= '0;
      left_q       <= LEFT_FULL;
      level_done_q <= 1'b0;
      land_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_move_q  <= done_move;
      pending_q    <= pending_d;
      pos_q        <= pos_d;
      color_q      <= color_d;
      mid_q        <= mid_d;
      left_q       <= left_d;
      level_done_q <= level_done_d;
      land_err_q   <= land_err_d;
    end
  end

`ifdef CUBE_WIN_FLASH_EN
  logic timer_pause, timer_flash, timer_done;

  // Timer only advances while the FSM sits in WIN and the game is running.
  assign timer_pause = e_pause_qb | (state_q != ST_WIN);

  cube_flash_timer #(
    .FLASH_HALF    (FLASH_HALF),
    .FLASH_TOGGLES (FLASH_TOGGLES)
  ) u_flash_timer (
    .clk   (CLK_33),
    .reset (reset),
    .start (win_start),
    .pause (timer_pause),
    .flash (timer_flash),
    .done  (timer_done)
  );

  assign win_done = timer_done;
  assign flash    = timer_flash & (state_q == ST_WIN);
`else
  logic unused_flash_cfg;

  assign unused_flash_cfg = ^{win_start, FLASH_HALF[0], FLASH_TOGGLES[0]};
  assign win_done         = 1'b1;
  assign flash            = 1'b0;
`endif

  assign color_state = color_q;
  assign color_mid   = mid_q;
  assign cubes_left  = left_q;
  assign level_done  = level_done_q;
  assign land_err    = land_err_q;
  assign ctrl_state  = state_q;

endmodule
